// File: rtl/prefix_add8_arbiter_pkg.sv
// Shared constants and the stage-1 payload type for the shared 8-bit adder
// arbiter. The id field is sized for the largest supported requester count,
// so one payload type serves every NREQ setting.
package prefix_add_pkg;

  localparam int ADD_W    = 8;
  localparam int DEF_NREQ = 4;
  localparam int MAX_NREQ = 8;
  localparam int ID_MAX_W = $clog2(MAX_NREQ);

  // Operand register contents: both addends plus the issuing requester.
  typedef struct packed {
    logic [ADD_W-1:0]    a;
    logic [ADD_W-1:0]    b;
    logic [ID_MAX_W-1:0] id;
  } stage_t;

endpackage

// File: rtl/prefix_add8_arbiter_if.sv
// Request/response bundle between the requesters, the response consumer and
// the shared adder arbiter.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready are
// both high. A source raising valid keeps valid and its payload stable until
// that transfer; ready may depend combinationally on valid. req_ready has at
// most one bit set. rsp_valid/rsp_id/rsp_sum stay stable while rsp_ready is low.
interface prefix_add8_arbiter_if #(
  parameter int NREQ = prefix_add_pkg::DEF_NREQ
);
  import prefix_add_pkg::*;

  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*ADD_W-1:0] req_a;
  logic [NREQ*ADD_W-1:0] req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [ADD_W-1:0]      rsp_sum;
  logic                  busy;

  // Requester and response-consumer side.
  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_sum, busy
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sum, busy
  );

endinterface

// File: rtl/prefix_add8.sv
// Combinational 8-bit Kogge-Stone adder, sum = a + b mod 256. The carry out
// of bit 7 is dropped.
module prefix_add8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] sum
);

  // g[l] / p[l]: group generate / propagate after l prefix levels.
  logic [7:0] g [0:3];
  logic [7:0] p [0:2];

  assign g[0] = a & b;
  assign p[0] = a ^ b;

  for (genvar l = 0; l < 3; l++) begin : g_lvl
    localparam int D = 1 << l;
    for (genvar i = 0; i < 8; i++) begin : g_bit
      if (i >= D) begin : g_comb
        assign g[l+1][i] = g[l][i] | (p[l][i] & g[l][i-D]);
        if (l < 2) begin : g_prop
          assign p[l+1][i] = p[l][i] & p[l][i-D];
        end
      end else begin : g_pass
        assign g[l+1][i] = g[l][i];
        if (l < 2) begin : g_prop
          assign p[l+1][i] = p[l][i];
        end
      end
    end
  end

  // Carry into bit i is the group generate of bits [i-1:0].
  assign sum = p[0] ^ {g[3][6:0], 1'b0};

  // Carry-out and the low final-level propagates have no consumer.
  logic unused_bits;
  assign unused_bits = g[3][7] ^ (^p[2][3:0]);

endmodule

// File: rtl/prefix_add8_arbiter_rr.sv
// Round-robin request picker: first asserted request at or after ptr,
// wrapping to 0. The grant is suppressed when en is low.
module rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            hit
);

  logic           found;
  logic [IDW-1:0] cand;

  // Scan from ptr upward with wrap; the first asserted request wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IDW'((int'(ptr) + k) % NREQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    hit   = found & en;
    grant = hit ? (NREQ'(1) << idx) : '0;
  end

endmodule

// File: rtl/prefix_add8_arbiter.sv
// Shares one prefix_add8 among NREQ requesters: round-robin grant into an
// operand register, adder between the operand and result registers, and a
// single tagged response channel.
module prefix_add8_arbiter
  import prefix_add_pkg::*;
#(
  parameter int NREQ = DEF_NREQ
) (
  input  logic                  clk,
  input  logic                  rst_n,
  prefix_add8_arbiter_if.slave  bus
);

  localparam int IDW = $clog2(NREQ);

  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   ptr_nxt;
  logic [IDW-1:0]   grant_idx;
  logic [NREQ-1:0]  grant;
  logic             accept;
  logic             adv2;
  logic             accept_en;
  stage_t           s1_q;
  stage_t           s1_d;
  logic             s1_valid;
  logic             s2_valid;
  logic [ADD_W-1:0] sum_c;
  logic [ADD_W-1:0] rsp_sum_q;
  logic [IDW-1:0]   rsp_id_q;

  // Stage 2 can take new data when empty or being drained; stage 1 when empty
  // or moving into stage 2. Grants are held off while reset is asserted.
  assign adv2      = !s2_valid | bus.rsp_ready;
  assign accept_en = (!s1_valid | adv2) & rst_n;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req   (bus.req_valid),
    .ptr   (ptr),
    .en    (accept_en),
    .grant (grant),
    .idx   (grant_idx),
    .hit   (accept)
  );

  assign bus.req_ready = grant;

  // Operand mux for the granted requester and the pointer that follows it.
  always_comb begin
    s1_d.a  = bus.req_a[int'(grant_idx)*ADD_W +: ADD_W];
    s1_d.b  = bus.req_b[int'(grant_idx)*ADD_W +: ADD_W];
    s1_d.id = ID_MAX_W'(grant_idx);
    ptr_nxt = (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + 1'b1;
  end

  // Stage 1: operand register and round-robin pointer; ptr moves only on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
      ptr      <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_q     <= s1_d;
      ptr      <= ptr_nxt;
    end else if (adv2) begin
      s1_valid <= 1'b0;
    end
  end

  prefix_add8 u_add (
    .a   (s1_q.a),
    .b   (s1_q.b),
    .sum (sum_c)
  );

  // Stage 2: result register, holds while the consumer back-pressures.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid  <= 1'b0;
      rsp_sum_q <= '0;
      rsp_id_q  <= '0;
    end else if (adv2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        rsp_sum_q <= sum_c;
        rsp_id_q  <= s1_q.id[IDW-1:0];
      end
    end
  end

  // Id bits above IDW are always zero for smaller requester counts.
  if (IDW < ID_MAX_W) begin : g_id_hi
    logic unused_id_hi;
    assign unused_id_hi = |s1_q.id[ID_MAX_W-1:IDW];
  end

  assign bus.rsp_valid = s2_valid;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_sum   = rsp_sum_q;
  assign bus.busy      = s1_valid | s2_valid;

endmodule
